// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle logic/arith ops, iterative 1-bit-per-clock shifts.
// Valid/ready on the request side, one-cycle done pulse on the result side.
module ula_seq #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUCtrl,
    input  logic             Shamt,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             done,
    output logic             busy,
    output logic             err
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLLV = 4'b0011;
    localparam logic [3:0] OP_SRLV = 4'b0100;
    localparam logic [3:0] OP_SRAV = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_BNE  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_XOR  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_UND  = 4'b1110;
    localparam logic [3:0] OP_SLTU = 4'b1111;

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    typedef enum logic [1:0] {
        K_LEFT,
        K_RLOG,
        K_RARI
    } kind_t;

    state_t           r_state;
    state_t           w_next;
    kind_t            r_kind;
    kind_t            w_kind;
    logic [WIDTH-1:0] r_work;
    logic [SHW-1:0]   r_cnt;
    logic             r_pend;
    logic [WIDTH-1:0] r_pres;
    logic             r_pz;
    logic             r_perr;

    logic             w_accept;
    logic             w_is_shift;
    logic             w_launch;
    logic [SHW-1:0]   w_amt;
    logic [WIDTH-1:0] w_res;
    logic             w_zero;
    logic             w_err;
    logic             w_slt;
    logic             w_sltu;
    logic [WIDTH-1:0] w_shifted;
    logic             w_last;

    assign in_ready = (r_state == S_IDLE);
    assign busy     = (r_state == S_SHIFT);
    assign w_accept = in_valid && in_ready;
    assign w_amt    = Shamt ? shamt : A[SHW-1:0];
    assign w_launch = w_accept && w_is_shift && (w_amt != '0);
    assign w_slt    = $signed(A) < $signed(B);
    assign w_sltu   = A < B;
    assign w_last   = (r_cnt == SHW'(1));

    always_comb begin
        w_is_shift = 1'b0;
        w_kind     = K_LEFT;
        case (ALUCtrl)
            OP_SLL, OP_SLLV: begin
                w_is_shift = 1'b1;
                w_kind     = K_LEFT;
            end
            OP_SRL, OP_SRLV: begin
                w_is_shift = 1'b1;
                w_kind     = K_RLOG;
            end
            OP_SRA, OP_SRAV: begin
                w_is_shift = 1'b1;
                w_kind     = K_RARI;
            end
            default: ;
        endcase
    end

    // Single-cycle result; a zero-amount shift degenerates to passing B through.
    always_comb begin
        w_res = '0;
        w_err = 1'b0;
        case (ALUCtrl)
            OP_AND:  w_res = A & B;
            OP_OR:   w_res = A | B;
            OP_XOR:  w_res = A ^ B;
            OP_NOR:  w_res = ~(A | B);
            OP_ADD:  w_res = A + B;
            OP_SUB:  w_res = A - B;
            OP_BNE:  w_res = A - B;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, w_slt};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, w_sltu};
            OP_UND:  w_err = 1'b1;
            default: w_res = B;
        endcase
        if (ALUCtrl == OP_BNE) begin
            w_zero = (A != B);
        end else begin
            w_zero = (w_res == '0);
        end
    end

    always_comb begin
        case (r_kind)
            K_RLOG:  w_shifted = {1'b0, r_work[WIDTH-1:1]};
            K_RARI:  w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            default: w_shifted = {r_work[WIDTH-2:0], 1'b0};
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_kind  <= K_LEFT;
            r_work  <= '0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_pres  <= '0;
            r_pz    <= 1'b0;
            r_perr  <= 1'b0;
            result  <= '0;
            zero    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_next;
            done    <= 1'b0;
            r_pend  <= w_accept && !w_launch;
            if (w_accept && !w_launch) begin
                r_pres <= w_res;
                r_pz   <= w_zero;
                r_perr <= w_err;
            end
            // Staged single-cycle result retires one clock after accept.
            if (r_pend) begin
                result <= r_pres;
                zero   <= r_pz;
                err    <= r_perr;
                done   <= 1'b1;
            end
            if (w_launch) begin
                r_work <= B;
                r_cnt  <= w_amt;
                r_kind <= w_kind;
            end else if (r_state == S_SHIFT) begin
                r_work <= w_shifted;
                r_cnt  <= r_cnt - SHW'(1);
                if (w_last) begin
                    result <= w_shifted;
                    zero   <= (w_shifted == '0);
                    err    <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: driver queues expectations, monitor checks on done.
module tb_ula_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  ALUCtrl = '0;
    logic        Shamt = 1'b0;
    logic [4:0]  shamt = '0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] result;
    logic        zero;
    logic        done;
    logic        busy;
    logic        err;

    ula_seq #(.WIDTH(32), .SHW(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .ALUCtrl(ALUCtrl), .Shamt(Shamt), .shamt(shamt), .A(A), .B(B),
        .result(result), .zero(zero), .done(done), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        e;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(string nm, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, want none", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_zero"}, {31'b0, zero}, {31'b0, e.z});
                check({e.name, "_err"}, {31'b0, err}, {31'b0, e.e});
                check({e.name, "_cycle"}, cyc, e.due);
            end
        end
    end

    task automatic issue(string nm, logic [3:0] op, logic sh, logic [4:0] sa,
                         logic [31:0] a, logic [31:0] b, logic [31:0] er,
                         logic ez, logic ee, int lat, bit push = 1'b1);
        ALUCtrl  = op;
        Shamt    = sh;
        shamt    = sa;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && in_ready !== 1'b1; i++) @(negedge clk);
        check({nm, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        if (push) sb.push_back('{er, ez, ee, cyc + 1 + lat, nm});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(string nm);
        in_valid = 1'b0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
        check({nm, "_drained"}, sb.size(), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b0;

        issue("add",  4'b0010, 0, 0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1);
        issue("sub",  4'b0110, 0, 0, 32'd5, 32'd5, 32'd0, 1, 0, 1);
        issue("slt",  4'b0111, 0, 0, 32'hFFFFFFFF, 32'h1, 32'd1, 0, 0, 1);
        issue("sltu", 4'b1111, 0, 0, 32'hFFFFFFFF, 32'h1, 32'd0, 1, 0, 1);
        issue("xor",  4'b1011, 0, 0, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 0, 0, 1);
        issue("nor",  4'b1100, 0, 0, 32'h0, 32'h0, 32'hFFFFFFFF, 0, 0, 1);

        issue("sra4", 4'b1101, 1, 5'd4, 32'h0, 32'h80000000, 32'hF8000000, 0, 0, 4);
        ALUCtrl  = 4'b0000;
        Shamt    = 1'b0;
        A        = 32'hF0;
        B        = 32'h3C;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("sra_busy", {31'b0, busy}, 32'd1);
            check("sra_not_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        check("sra_busy_end", {31'b0, busy}, 32'd0);
        issue("held_and", 4'b0000, 0, 0, 32'hF0, 32'h3C, 32'h30, 0, 0, 1);

        issue("sllv0", 4'b0011, 0, 0, 32'h0, 32'h1234, 32'h1234, 0, 0, 1);
        issue("srlv31", 4'b0100, 0, 0, 32'd31, 32'h80000000, 32'd1, 0, 0, 31);
        issue("srl1", 4'b1010, 1, 5'd1, 32'h0, 32'h2, 32'd1, 0, 0, 1);
        issue("srav1", 4'b0101, 0, 0, 32'h21, 32'h80000000, 32'hC0000000, 0, 0, 1);
        issue("bne_eq", 4'b1000, 0, 0, 32'd3, 32'd3, 32'd0, 0, 0, 1);
        issue("bne_ne", 4'b1000, 0, 0, 32'd3, 32'd4, 32'hFFFFFFFF, 1, 0, 1);
        issue("undef", 4'b1110, 0, 0, 32'd5, 32'd6, 32'd0, 1, 1, 1);
        issue("b2b_and", 4'b0000, 0, 0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 0, 0, 1);
        issue("b2b_or", 4'b0001, 0, 0, 32'hFF00FF00, 32'h0F0F0F0F, 32'hFF0FFF0F, 0, 0, 1);
        drain("main");

        issue("sll_abort", 4'b1001, 1, 5'd20, 32'h0, 32'h1, 32'h0, 0, 0, 20, 1'b0);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b0;
        issue("add_after", 4'b0010, 0, 0, 32'd2, 32'd3, 32'd5, 0, 0, 1);
        drain("after");
        repeat (25) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Sequential ALU (ULA) that executes the 4-bit ALUCtrl codes produced by the ALU control decoder.
- Single-cycle ops complete in one clock. Shifts run iteratively, one bit position per clock, to keep the combinational path short.
- Sits between the decode/register-read stage and write-back.
- Uses a valid/ready handshake on the input side and a done pulse on the output side.

Parameters:
- WIDTH, 32, operand/result width.
- SHW, 5, shift-amount width (log2 WIDTH).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- ALUCtrl  input  4  operation code.
- Shamt  input  1  1 = shift amount from shamt field; 0 = from A[SHW-1:0].
- shamt  input  SHW  instruction shamt field.
- A  input  WIDTH  operand rs.
- B  input  WIDTH  operand rt/immediate.
- result  output  WIDTH  operation result, held until the next accept.
- zero  output  1  branch/compare flag, held with result.
- done  output  1  one-cycle pulse when result/zero become valid.
- busy  output  1  high in SHIFT state.
- err  output  1  undefined ALUCtrl on the last accepted op, held with result.

Behaviour:
- Clock and reset:
  - Single clock, clk. Reset is synchronous and active-high, signal reset.
  - Reset values: state=IDLE, result=0, zero=0, done=0, busy=0, err=0, in_ready=1 (combinational from state).
- Accept and latency:
  - Accept when in_valid && in_ready at a rising edge. Operands, code, and shift amount are latched at accept.
  - Inputs may change freely after accept.
- Code map (ALUCtrl -> operation):
  - 0000 AND, 0001 OR, 1011 XOR, 1100 NOR.
  - 0010 ADD (mod 2^WIDTH, no overflow trap).
  - 0110 SUB (A-B).
  - 0111 SLT: signed A<B -> 1 else 0.
  - 1111 SLTU: unsigned A<B -> 1 else 0.
  - 1000 BNE: result=A-B, zero=(A!=B).
  - 1001 SLL, 1010 SRL, 1101 SRA.
  - 0011 SLLV, 0100 SRLV, 0101 SRAV.
  - 1110: undefined -> result=0, zero=1, err=1.
- Zero flag:
  - For all codes except 1000, zero=(result==0), computed on the final result.
- Shifts:
  - The shifted operand is always B.
  - amount = Shamt ? shamt : A[SHW-1:0], latched at accept.
  - SRA/SRAV replicate B[WIDTH-1] on every step.
- FSM states and transitions:
  - IDLE:
    - Accept of a non-shift op: compute in the accept cycle, register result/zero/err, pulse done on the next cycle. Stays in IDLE.
    - Accept of a shift op with amount=0: result=B, done next cycle. Stays in IDLE.
    - Accept of a shift op with amount>0: load work register=B, counter=amount, go to SHIFT.
  - SHIFT:
    - busy=1, in_ready=0. Each cycle: shift work register 1 position, counter--.
    - When counter reaches 0: result=work, zero computed, done pulses, return to IDLE.
    - A shift of k>0 accepted at edge N asserts done for the cycle after edge N+k.
- Latency and throughput:
  - Non-shift op accepted at edge N: done high between edges N+1 and N+2.
  - Back-to-back non-shift ops are accepted every cycle. in_ready stays 1 in IDLE even while done is high.
- done:
  - Strictly one cycle per accepted op.
  - result/zero/err update only on the done cycle and are held otherwise.
- Reset mid-operation: reset in SHIFT aborts the shift, no done pulse, all outputs return to reset values next cycle.
- Simultaneous events: in_valid during SHIFT is ignored (not queued). Reset has priority over accept.

Test Plan:
- Reset: assert reset 2 cycles -> result=0, zero=0, done=0, busy=0, in_ready=1.
- ADD/SUB/SLT/SLTU:
  - ADD A=0x7FFFFFFF, B=1 -> result=0x80000000, zero=0, done 1 cycle after accept.
  - SUB A=B=5 -> result=0, zero=1.
  - SLT A=0xFFFFFFFF, B=1 -> 1.
  - SLTU same operands -> 0.
- SRA with shamt:
  - SRA Shamt=1 shamt=4, B=0x80000000 -> busy 4 cycles, in_ready=0, then result=0xF8000000, single done pulse.
  - in_valid held during busy is not accepted.
- Variable shifts:
  - SLLV Shamt=0 A=0 B=0x1234 -> result=0x1234, done 1 cycle after accept.
  - SRLV A=31 B=0x80000000 -> result=1 after 31 shift cycles.
- Branch and undefined codes:
  - BNE A=3 B=3 -> zero=0.
  - BNE A=3 B=4 -> zero=1.
  - Code 1110 -> result=0, err=1.
  - Back-to-back AND then OR on consecutive cycles -> two consecutive done pulses with correct results.
- Reset mid-shift: SLL amount=20, assert reset on shift cycle 5 -> no done, busy=0 and result=0 next cycle. A new ADD is then accepted normally.
